// File: rtl/serv_gpu_pkg.sv
// Shared types and constants for the SERV data-bus arbiter.
package serv_gpu_pkg;

    localparam int unsigned DBUS_AW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } arb_state_e;

    // One core's Wishbone data-bus request, captured at grant time.
    typedef struct packed {
        logic [DBUS_AW-1:0] adr;
        logic [31:0]        dat;
        logic [3:0]         sel;
        logic               we;
    } dbus_req_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: lowest requesting index at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic             hi_valid;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Scan downwards so the lowest index wins; "hi" covers indices at or above the pointer.
    always_comb begin
        valid_o  = 1'b0;
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                valid_o = 1'b1;
                lo_idx  = IDX_W'(k);
                if (k >= int'(ptr_i)) begin
                    hi_valid = 1'b1;
                    hi_idx   = IDX_W'(k);
                end
            end
        end
        idx_o = hi_valid ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/serv_dbus_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between N SERV dbus ports.
module serv_dbus_arbiter
    import serv_gpu_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int unsigned MEM_AW   = $clog2(MEM_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DBUS_AW*NUM_CORES-1:0] i_core_adr,
    input  logic [32*NUM_CORES-1:0]      i_core_dat,
    input  logic [4*NUM_CORES-1:0]       i_core_sel,
    input  logic [NUM_CORES-1:0]         i_core_we,
    input  logic [NUM_CORES-1:0]         i_core_cyc,
    output logic [NUM_CORES-1:0]         o_core_ack,
    output logic [31:0]                  o_core_rdt,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [MEM_AW-1:0]            o_mem_addr,
    output logic [31:0]                  o_mem_wdata,
    output logic [3:0]                   o_mem_sel,
    input  logic [31:0]                  i_mem_rdata,
    output logic [IDX_W-1:0]             o_grant,
    output logic                         o_busy
);

    localparam logic [DBUS_AW:0] MemBytes = (DBUS_AW + 1)'(MEM_WORDS) << 2;

    arb_state_e           state_q, state_d;
    dbus_req_t            req_q, req_d;
    dbus_req_t            win_req;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [NUM_CORES-1:0] eff_req;
    logic                 dec_err_q, dec_err_d;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 out_of_range;

    // The just-acked core is masked for one IDLE cycle: SERV's cyc is still high then.
    assign eff_req      = i_core_cyc & ~mask_q;
    assign out_of_range = {1'b0, req_q.adr} >= MemBytes;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req_i   (eff_req),
        .ptr_i   (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Select the winning core's request fields.
    always_comb begin
        win_req = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                win_req.adr = i_core_adr[DBUS_AW*k +: DBUS_AW];
                win_req.dat = i_core_dat[32*k +: 32];
                win_req.sel = i_core_sel[4*k +: 4];
                win_req.we  = i_core_we[k];
            end
        end
    end

    // Next-state: grant and latch in IDLE, flag decode error in ACCESS, advance pointer in ACK.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        mask_d    = mask_q;
        dec_err_d = dec_err_q;
        unique case (state_q)
            IDLE: begin
                mask_d = '0;
                if (pick_valid) begin
                    grant_d = pick_idx;
                    req_d   = win_req;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                dec_err_d = out_of_range;
                state_d   = ACK;
            end
            ACK: begin
                rr_d = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
                for (int k = 0; k < NUM_CORES; k++) begin
                    mask_d[k] = (grant_q == IDX_W'(k));
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state and latched request.
    always_comb begin
        o_core_ack  = '0;
        o_core_rdt  = '0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_sel   = '0;
        o_busy      = (state_q == ACCESS) || (state_q == ACK);
        o_grant     = grant_q;
        if (state_q == ACCESS && !out_of_range) begin
            o_mem_en    = 1'b1;
            o_mem_we    = req_q.we;
            o_mem_addr  = req_q.adr[MEM_AW+1:2];
            o_mem_wdata = req_q.dat;
            o_mem_sel   = req_q.sel;
        end
        if (state_q == ACK) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                o_core_ack[k] = (grant_q == IDX_W'(k));
            end
            if (!req_q.we && !dec_err_q) begin
                o_core_rdt = i_mem_rdata;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            mask_q    <= '0;
            dec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            mask_q    <= mask_d;
            dec_err_q <= dec_err_d;
        end
    end

endmodule

// File: doc/serv_dbus_arbiter.md
Name: serv_dbus_arbiter

Overview:
- Sits between the N SERV cores' Wishbone data-bus ports and the single shared data memory. It replaces the direct core-0 wiring at the top level.
- Arbitrates per-core requests round-robin, drives one synchronous-read/synchronous-write memory port, and returns one ack per transaction to the granted core.
- Each core's byte-select lanes are carried separately.
- Out-of-range addresses (including the 0xFFFFFFFF completion sentinel) are acked without touching memory.

Parameters:
- NUM_CORES, 4: number of requesting cores; legal range 1..16.
- MEM_WORDS, 1024: depth of the shared memory in 32-bit words; addresses at or above MEM_WORDS*4 are out of range.
- IDX_W, $clog2(NUM_CORES) (minimum 1): width of the grant index.

Ports:
- clk  in  1  — system clock, rising edge.
- rst_n  in  1  — reset; synchronous, active-low.
- i_core_adr  in  32*NUM_CORES  — per-core byte address; core k occupies bits [32k+31:32k].
- i_core_dat  in  32*NUM_CORES  — per-core write data.
- i_core_sel  in  4*NUM_CORES  — per-core byte enables.
- i_core_we  in  NUM_CORES  — per-core write strobe.
- i_core_cyc  in  NUM_CORES  — per-core request, held high until acked.
- o_core_ack  out  NUM_CORES  — one-cycle ack, one-hot or zero.
- o_core_rdt  out  32  — read data broadcast to all cores; valid only with ack.
- o_mem_en  out  1  — memory access strobe.
- o_mem_we  out  1  — memory write enable.
- o_mem_addr  out  $clog2(MEM_WORDS)  — word address (byte address >> 2).
- o_mem_wdata  out  32  — memory write data.
- o_mem_sel  out  4  — memory byte enables.
- i_mem_rdata  in  32  — memory read data, valid one cycle after an o_mem_en read.
- o_grant  out  IDX_W  — index of the current or last granted core.
- o_busy  out  1  — high in the ACCESS and ACK states.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State = IDLE, rr pointer = 0, o_grant = 0, mask cleared.
  - All outputs are 0 at the next cycle.
  - Reset mid-transaction abandons the transaction: no ack, no further memory strobe.
- States: IDLE → ACCESS → ACK → IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - Effective requests = i_core_cyc & ~mask.
  - If any effective request: pick the lowest index at or after rr pointer, wrapping modulo NUM_CORES.
  - On that edge, register the grant index plus the winner's adr/dat/sel/we, then go to ACCESS.
  - The mask clears after one IDLE cycle.
- ACCESS:
  - In range: o_mem_en = 1; o_mem_we = latched we; o_mem_addr/wdata/sel come from the latched request.
  - Out of range (adr >= MEM_WORDS*4): o_mem_en = 0 and a decode-error flag is set.
- ACK:
  - o_core_ack[grant] = 1.
  - o_core_rdt = i_mem_rdata for an in-range read; 0 for writes or decode error.
  - On exit: rr pointer = grant+1 (wrapping), mask = one-hot(grant).
- The mask blocks the just-acked core for the following IDLE cycle. This covers the cycle in which SERV's registered cyc is still high after the ack and prevents a double access.
- Latency: cyc high in IDLE cycle c → mem strobe in c+1 → ack in c+2 → next grant decision in c+3. Steady-state throughput is 1 transaction per 3 cycles.
- Latched request: once granted, the transaction completes from the latched values.
  - Changes to core inputs after grant are ignored.
  - If cyc drops after grant, the write is still performed and the ack still pulses.
- Outside ACK, o_core_ack = 0 and o_core_rdt = 0. Outside ACCESS, o_mem_en = 0 and o_mem_we = 0.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 transactions.
- NUM_CORES = 1: the pointer stays 0 and the mask still imposes one idle cycle between transactions.

Decomposition:
- Package serv_gpu_pkg:
  - typedef arb_state_e {IDLE, ACCESS, ACK};
  - constant DBUS_AW = 32;
  - typedef dbus_req_t {adr, dat, sel, we}.
- Sub-module rr_pick (combinational): inputs req vector and pointer; outputs a valid flag and the winning index. The FSM and request latching stay in the top module.

Test Plan:
- Single read: after reset, write mem[5] = 0xDEADBEEF by backdoor. Core 0 requests adr 0x14, we = 0 at cycle c → o_mem_en and o_mem_addr = 5 at c+1; ack[0] with rdt = 0xDEADBEEF at c+2; no other ack.
- Byte write: core 2 writes adr 0x8, dat 0x11223344, sel 0b0100 → in the ACCESS cycle o_mem_we = 1, o_mem_addr = 2, o_mem_sel = 0b0100; ack[2] one cycle later.
- Round-robin: cores 0–3 hold cyc from reset → grant order 0, 1, 2, 3, 0; acks exactly 3 cycles apart.
- No double access: core 1 holds cyc one cycle after its ack while core 3 is idle → that cycle yields no grant; a new core 1 transaction starts only if cyc is still high in the next cycle.
- Decode error: core 0 reads adr 0xFFFFFFFF → o_mem_en stays 0; ack[0] with rdt = 0 at c+2.
- Reset mid-op: drop rst_n in the ACCESS cycle → no ack; all outputs 0 at the next cycle; a fresh request is granted normally afterwards.
